// File: rtl/dm_bytewrite.sv
// MEM-stage data memory: byte-lane merge on store, combinational load read, post-reset clear sweep.
// Optional write log compiled in with DM_WRITE_LOG_EN.
module dm_bytewrite #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] Adr,
  input  logic [31:0] Din,
  input  logic [1:0]  WLen,
  input  logic [31:0] PC,
  output logic [31:0] Dout,
  output logic        busy,
  output logic        err,
  output logic        err_sticky
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              err_sticky_q, err_sticky_d;

  logic [31:0]       mem_q [Depth];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic [2:0]        start, last;
  logic [3:0]        be;
  logic              oor, illegal, commit;
  logic [31:0]       merged;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign idx     = Adr[ADDR_W+1:2];
  assign rd_word = mem_q[idx];

  always_comb begin
    start   = {1'b0, Adr[1:0]};
    last    = start + {1'b0, WLen};
    oor     = |Adr[31:ADDR_W+2];
    illegal = (last > 3'd3) || ((WLen == 2'b01) && Adr[0]) || oor;
    be      = '0;
    merged  = rd_word;
    for (int i = 0; i < 4; i++) begin
      be[i] = WE && (3'(i) >= start) && (3'(i) <= last);
      if (be[i]) merged[8*i +: 8] = Din[8*i +: 8];
    end
  end

  // Stores arriving during the sweep are dropped silently, so they never raise err.
  assign commit = WE && !busy_q && !illegal;
  assign err    = WE ? (illegal && !busy_q) : oor;
  assign Dout   = (busy_q || oor) ? 32'h0 : rd_word;

  // Reset at the same edge as a write must lose the write.
  always_comb begin
    mem_we    = !reset && (busy_q || commit);
    mem_waddr = busy_q ? cnt_q : idx;
    mem_wdata = busy_q ? 32'h0 : merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    err_sticky_d = err_sticky_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StIdle: begin
        if (WE && err) err_sticky_d = 1'b1;
      end
      default: begin
        state_d = StClear;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign busy       = busy_q;
  assign err_sticky = err_sticky_q;

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      $display("%d@%h: *%h <= %h", $time, PC, {Adr[31:2], 2'b00}, merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_bytewrite.sv
// Scoreboard bench for dm_bytewrite: stimulus queues expectations, a negedge monitor checks them.
module tb_dm_bytewrite;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] Adr;
  logic [31:0] Din;
  logic [1:0]  WLen;
  logic [31:0] PC;
  logic [31:0] Dout;
  logic        busy;
  logic        err;
  logic        err_sticky;

  dm_bytewrite #(.ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (WE),
    .Adr        (Adr),
    .Din        (Din),
    .WLen       (WLen),
    .PC         (PC),
    .Dout       (Dout),
    .busy       (busy),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        err;
    logic        busy;
    logic        sticky;
  } exp_t;

  exp_t sb_q[$];
  logic chk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: the DUT "presents" an output on every cycle the bench flags with chk.
  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: scoreboard empty, got dout=%h err=%b busy=%b sticky=%b",
                 "no_expect", Dout, err, busy, err_sticky);
      end else begin
        e = sb_q.pop_front();
        if (Dout !== e.dout || err !== e.err || busy !== e.busy || err_sticky !== e.sticky) begin
          n_bad++;
          $display("FAIL %s: got dout=%h err=%b busy=%b sticky=%b, want dout=%h err=%b busy=%b sticky=%b",
                   e.name, Dout, err, busy, err_sticky, e.dout, e.err, e.busy, e.sticky);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] d, input logic e, input logic b,
                      input logic s);
    exp_t x;
    x.name = nm; x.dout = d; x.err = e; x.busy = b; x.sticky = s;
    sb_q.push_back(x);
  endtask

  // Apply one access for one cycle and queue its expected outputs (sampled before the edge).
  task automatic access(input string nm, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] wl, input logic [31:0] xd,
                        input logic xe, input logic xb, input logic xs);
    WE = we; Adr = a; Din = d; WLen = wl; PC = PC + 32'd4;
    push(nm, xd, xe, xb, xs);
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0; WE = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wl);
    WE = 1'b1; Adr = a; Din = d; WLen = wl; PC = PC + 32'd4;
    @(posedge clk); #1;
    WE = 1'b0;
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Count edges from reset release until busy drops; optionally try a store mid-sweep.
  task automatic sweep(input string nm, input int store_at);
    int n = 0;
    while (n < 2000) begin
      if (n == store_at) begin
        WE = 1'b1; Adr = 32'h40; Din = 32'hDEADBEEF; WLen = 2'b11;
        push("store_busy", 32'h0, 1'b0, 1'b1, 1'b0);
        chk = 1'b1;
      end
      @(posedge clk); #1;
      WE = 1'b0; chk = 1'b0;
      n++;
      if (!busy) break;
    end
    check_int(nm, n, 1024);
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; Adr = '0; Din = '0; WLen = '0; PC = 32'h0040_0000;
    @(posedge clk); #1;
    access("reset_state", 1'b0, 32'h10, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    sweep("sweep1_len", -1);

    access("zero_0x000", 1'b0, 32'h000, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    access("zero_0xffc", 1'b0, 32'hFFC, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    store(32'h10, 32'h11223344, 2'b11);
    store(32'h12, 32'h00AA0000, 2'b00);
    access("byte_merge", 1'b0, 32'h10, 32'h0, 2'b00, 32'h11AA3344, 1'b0, 1'b0, 1'b0);
    store(32'h13, 32'h55000000, 2'b00);
    access("byte_lane3", 1'b0, 32'h10, 32'h0, 2'b00, 32'h55AA3344, 1'b0, 1'b0, 1'b0);

    store(32'h20, 32'hFFFFFFFF, 2'b11);
    store(32'h20, 32'h00000012, 2'b01);
    access("half_low", 1'b0, 32'h20, 32'h0, 2'b00, 32'hFFFF0012, 1'b0, 1'b0, 1'b0);
    store(32'h21, 32'hABCDEF00, 2'b10);
    access("tri_high", 1'b0, 32'h20, 32'h0, 2'b00, 32'hABCDEF12, 1'b0, 1'b0, 1'b0);

    // No bypass: during the store the old word is still read.
    access("cross_word", 1'b1, 32'h23, 32'h11000000, 2'b01, 32'hABCDEF12, 1'b1, 1'b0, 1'b0);
    access("cross_keep", 1'b0, 32'h20, 32'h0, 2'b00, 32'hABCDEF12, 1'b0, 1'b0, 1'b1);

    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    sweep("sweep_rst_len", -1);
    access("sticky_clr", 1'b0, 32'h20, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    access("half_odd", 1'b1, 32'h31, 32'h00BBCC00, 2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
    access("half_odd_keep", 1'b0, 32'h30, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    access("oor_store", 1'b1, 32'h1000, 32'hCAFEF00D, 2'b11, 32'h0, 1'b1, 1'b0, 1'b1);
    access("oor_alias", 1'b0, 32'h000, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    access("oor_read", 1'b0, 32'h2000, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    store(32'h40, 32'h12345678, 2'b11);
    access("pre_sweep_40", 1'b0, 32'h40, 32'h0, 2'b00, 32'h12345678, 1'b0, 1'b0, 1'b1);

    // Reset mid-sweep, then a dropped store well after word 0x40 is swept.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 499; i++) begin
      @(posedge clk); #1;
    end
    access("mid_sweep_busy", 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    access("mid_sweep_rst", 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    sweep("sweep2_len", 200);
    access("dropped_40", 1'b0, 32'h40, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check_int("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by 200000, want finish");
    $fatal(1, "timeout");
  end

endmodule
